// File: rtl/ex_muldiv_if.sv
// ID/EX input bundle and registered EX/MEM output bundle of the execute stage.
// master = upstream/pipeline side, slave = the execute stage itself.
interface ex_muldiv_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 30,
  parameter int MEM_OP_W   = 2,
  parameter int CTRL_OP_W  = 2,
  parameter int REG_ADDR_W = 5,
  parameter int EXP_W      = 3
);
  logic [ADDR_W-1:0]     id_pc;
  logic                  id_en;
  logic [3:0]            id_op;
  logic [DATA_W-1:0]     id_in_0;
  logic [DATA_W-1:0]     id_in_1;
  logic                  id_br_flag;
  logic [MEM_OP_W-1:0]   id_mem_op;
  logic [DATA_W-1:0]     id_mem_wr_data;
  logic [CTRL_OP_W-1:0]  id_ctrl_op;
  logic [REG_ADDR_W-1:0] id_dst_addr;
  logic                  id_gpr_we_;
  logic [EXP_W-1:0]      id_exp_code;

  logic [ADDR_W-1:0]     ex_pc;
  logic                  ex_en;
  logic                  ex_br_flag;
  logic [MEM_OP_W-1:0]   ex_mem_op;
  logic [DATA_W-1:0]     ex_mem_wr_data;
  logic [CTRL_OP_W-1:0]  ex_ctrl_op;
  logic [REG_ADDR_W-1:0] ex_dst_addr;
  logic                  ex_gpr_we_;
  logic [EXP_W-1:0]      ex_exp_code;
  logic [DATA_W-1:0]     ex_out;

  modport master (
    output id_pc, id_en, id_op, id_in_0, id_in_1, id_br_flag, id_mem_op,
           id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_, id_exp_code,
    input  ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op,
           ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out
  );

  modport slave (
    input  id_pc, id_en, id_op, id_in_0, id_in_1, id_br_flag, id_mem_op,
           id_mem_wr_data, id_ctrl_op, id_dst_addr, id_gpr_we_, id_exp_code,
    output ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op,
           ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out
  );
endinterface

// File: rtl/ex_muldiv_stage.sv
// Execute stage: single-cycle ALU plus an iterative bit-serial multiply/divide
// unit, feeding the EX/MEM pipeline register.
//
// state | meaning
// IDLE  | ALU path active; a MUL/MULHU/DIVU/REMU issue starts the iterative unit
// RUN   | one multiply/divide bit per cycle, counter counts DATA_W-1 down to 0
// DONE  | iterative result presented; leaves when the EX/MEM register can load
module ex_muldiv_stage #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 30,
  parameter int MEM_OP_W   = 2,
  parameter int CTRL_OP_W  = 2,
  parameter int REG_ADDR_W = 5,
  parameter int EXP_W      = 3,
  parameter int EXP_OVF    = 3,
  parameter int EXP_DIV0   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              int_detect,
  output logic              busy,
  output logic [DATA_W-1:0] fwd_data,
  ex_muldiv_if.slave        bus
);
  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [SH_W-1:0]     cnt;
  logic [2*DATA_W-1:0] acc, acc_nxt;
  logic [DATA_W-1:0]   dvs;
  logic [1:0]          op_q;
  logic                start, squash;

  logic [DATA_W-1:0]   sum, dif, alu_res, mc_res, res;
  logic                ovf;
  logic [EXP_W-1:0]    alu_exp, mc_exp, res_exp;
  logic [DATA_W:0]     msum, rsh, rdif;

  assign squash = flush | int_detect;
  assign start  = (state == IDLE) && bus.id_en && (bus.id_op[3:2] == 2'b10) && !squash;
  assign busy   = start || (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (squash) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (cnt == '0) state_nxt = DONE;
        DONE:    if (!stall) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // op_q[1] selects divide; acc holds {hi, lo} for multiply, {remainder, quotient} for divide
  always_comb begin
    msum    = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, dvs} : '0);
    rsh     = acc[2*DATA_W-1:DATA_W-1];
    rdif    = rsh - {1'b0, dvs};
    acc_nxt = acc;
    if (!op_q[1])
      acc_nxt = {msum, acc[DATA_W-1:1]};
    else if (!rdif[DATA_W])
      acc_nxt = {rdif[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
    else
      acc_nxt = {acc[2*DATA_W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      acc  <= '0;
      dvs  <= '0;
      op_q <= '0;
    end else if (state == IDLE && start) begin
      cnt  <= SH_W'(DATA_W - 1);
      acc  <= {{DATA_W{1'b0}}, bus.id_in_0};
      dvs  <= bus.id_in_1;
      op_q <= bus.id_op[1:0];
    end else if (state == RUN) begin
      cnt  <= cnt - SH_W'(1);
      acc  <= acc_nxt;
    end
  end

  // Divide by zero falls out of the restoring loop as quotient=all-ones, remainder=dividend
  always_comb begin
    case (op_q)
      2'd0:    mc_res = acc[DATA_W-1:0];
      2'd1:    mc_res = acc[2*DATA_W-1:DATA_W];
      2'd2:    mc_res = acc[DATA_W-1:0];
      default: mc_res = acc[2*DATA_W-1:DATA_W];
    endcase
    mc_exp = bus.id_exp_code;
    if (op_q[1] && dvs == '0 && bus.id_exp_code == '0) mc_exp = EXP_W'(EXP_DIV0);
  end

  always_comb begin
    sum     = bus.id_in_0 + bus.id_in_1;
    dif     = bus.id_in_0 - bus.id_in_1;
    ovf     = 1'b0;
    alu_res = bus.id_in_0;
    case (bus.id_op)
      4'd1: begin
        alu_res = sum;
        ovf = (bus.id_in_0[DATA_W-1] == bus.id_in_1[DATA_W-1]) &&
              (sum[DATA_W-1] != bus.id_in_0[DATA_W-1]);
      end
      4'd2: begin
        alu_res = dif;
        ovf = (bus.id_in_0[DATA_W-1] != bus.id_in_1[DATA_W-1]) &&
              (dif[DATA_W-1] != bus.id_in_0[DATA_W-1]);
      end
      4'd3:    alu_res = bus.id_in_0 & bus.id_in_1;
      4'd4:    alu_res = bus.id_in_0 | bus.id_in_1;
      4'd5:    alu_res = bus.id_in_0 ^ bus.id_in_1;
      4'd6:    alu_res = bus.id_in_0 << bus.id_in_1[SH_W-1:0];
      4'd7:    alu_res = bus.id_in_0 >> bus.id_in_1[SH_W-1:0];
      default: alu_res = bus.id_in_0;
    endcase
    alu_exp = (ovf && bus.id_exp_code == '0) ? EXP_W'(EXP_OVF) : bus.id_exp_code;
  end

  assign res      = (state == DONE) ? mc_res : alu_res;
  assign res_exp  = (state == DONE) ? mc_exp : alu_exp;
  assign fwd_data = res;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ex_pc          <= '0;
      bus.ex_en          <= 1'b0;
      bus.ex_br_flag     <= 1'b0;
      bus.ex_mem_op      <= '0;
      bus.ex_mem_wr_data <= '0;
      bus.ex_ctrl_op     <= '0;
      bus.ex_dst_addr    <= '0;
      bus.ex_gpr_we_     <= 1'b1;
      bus.ex_exp_code    <= '0;
      bus.ex_out         <= '0;
    end else if (!stall) begin
      bus.ex_pc          <= bus.id_pc;
      bus.ex_dst_addr    <= bus.id_dst_addr;
      bus.ex_mem_wr_data <= bus.id_mem_wr_data;
      if (squash || busy || !bus.id_en) begin
        bus.ex_en       <= 1'b0;
        bus.ex_br_flag  <= 1'b0;
        bus.ex_mem_op   <= '0;
        bus.ex_ctrl_op  <= '0;
        bus.ex_gpr_we_  <= 1'b1;
        bus.ex_exp_code <= '0;
        bus.ex_out      <= '0;
      end else begin
        bus.ex_en       <= 1'b1;
        bus.ex_br_flag  <= bus.id_br_flag;
        bus.ex_mem_op   <= bus.id_mem_op;
        bus.ex_ctrl_op  <= bus.id_ctrl_op;
        bus.ex_gpr_we_  <= bus.id_gpr_we_;
        bus.ex_exp_code <= res_exp;
        bus.ex_out      <= res;
      end
    end
  end
endmodule
